// File: rtl/eth_echo_64.sv
`default_nettype none
// ============================================================================
//  Module   : eth_echo_64
//  Purpose  : Ethernet frame responder, 64-bit datapath. Each received frame
//             that passes the destination filter is echoed back with the
//             MAC addresses swapped (reply source = LOCAL_MAC) and the
//             original EtherType and payload. Rejected frames are drained.
//  Ports    : clk, rst                - clock, async active-high reset
//             input_eth_hdr_*         - received header (valid/ready/fields)
//             input_eth_payload_*     - received AXI-Stream payload
//             output_eth_hdr_*        - reply header (valid/ready/fields)
//             output_eth_payload_*    - reply AXI-Stream payload
//             frame_count/drop_count  - replied / discarded frame counters
//             busy                    - frame in progress or reply pending
//  Revision : 1.0 - initial release
// ============================================================================
module eth_echo_64 #(
    parameter logic [47:0] LOCAL_MAC     = 48'h02_00_00_00_00_00,
    parameter int          ENABLE_FILTER = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        input_eth_hdr_valid,
    output logic        input_eth_hdr_ready,
    input  logic [47:0] input_eth_dest_mac,
    input  logic [47:0] input_eth_src_mac,
    input  logic [15:0] input_eth_type,
    input  logic [63:0] input_eth_payload_tdata,
    input  logic [7:0]  input_eth_payload_tkeep,
    input  logic        input_eth_payload_tvalid,
    output logic        input_eth_payload_tready,
    input  logic        input_eth_payload_tlast,
    input  logic        input_eth_payload_tuser,

    output logic        output_eth_hdr_valid,
    input  logic        output_eth_hdr_ready,
    output logic [47:0] output_eth_dest_mac,
    output logic [47:0] output_eth_src_mac,
    output logic [15:0] output_eth_type,
    output logic [63:0] output_eth_payload_tdata,
    output logic [7:0]  output_eth_payload_tkeep,
    output logic        output_eth_payload_tvalid,
    input  logic        output_eth_payload_tready,
    output logic        output_eth_payload_tlast,
    output logic        output_eth_payload_tuser,

    output logic [31:0] frame_count,
    output logic [31:0] drop_count,
    output logic        busy
);

    localparam logic [47:0] c_BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORWARD = 2'd1,
        DROP    = 2'd2
    } state_t;

    state_t      r_state_q,      w_state_d;
    logic        r_hdr_valid_q,  w_hdr_valid_d;
    logic [47:0] r_dest_mac_q,   w_dest_mac_d;
    logic [47:0] r_src_mac_q,    w_src_mac_d;
    logic [15:0] r_type_q,       w_type_d;
    logic [31:0] r_frame_cnt_q,  w_frame_cnt_d;
    logic [31:0] r_drop_cnt_q,   w_drop_cnt_d;

    logic w_in_hdr_ready;
    logic w_hdr_fire;
    logic w_filter_pass;
    logic w_in_pl_ready;
    logic w_out_pl_valid;

    // A new header is only taken in IDLE and only once the previous reply
    // header has been handed off, so reply headers can never be overwritten.
    assign w_in_hdr_ready = (r_state_q == IDLE) && !r_hdr_valid_q;
    assign w_hdr_fire     = input_eth_hdr_valid && w_in_hdr_ready;
    assign w_filter_pass  = (ENABLE_FILTER == 0)
                         || (input_eth_dest_mac == LOCAL_MAC)
                         || (input_eth_dest_mac == c_BCAST_MAC);

    always_comb begin
        w_state_d      = r_state_q;
        w_hdr_valid_d  = r_hdr_valid_q;
        w_dest_mac_d   = r_dest_mac_q;
        w_src_mac_d    = r_src_mac_q;
        w_type_d       = r_type_q;
        w_frame_cnt_d  = r_frame_cnt_q;
        w_drop_cnt_d   = r_drop_cnt_q;
        w_in_pl_ready  = 1'b0;
        w_out_pl_valid = 1'b0;

        // Reply header handshake is decoupled from payload progress.
        if (r_hdr_valid_q && output_eth_hdr_ready) begin
            w_hdr_valid_d = 1'b0;
        end

        case (r_state_q)
            IDLE: begin
                if (w_hdr_fire) begin
                    if (w_filter_pass) begin
                        w_dest_mac_d  = input_eth_src_mac;
                        w_src_mac_d   = LOCAL_MAC;
                        w_type_d      = input_eth_type;
                        w_hdr_valid_d = 1'b1;
                        w_state_d     = FORWARD;
                    end else begin
                        w_drop_cnt_d  = r_drop_cnt_q + 32'd1;
                        w_state_d     = DROP;
                    end
                end
            end
            FORWARD: begin
                // Zero-latency pass-through: ready/valid are wired across.
                w_in_pl_ready  = output_eth_payload_tready;
                w_out_pl_valid = input_eth_payload_tvalid;
                if (input_eth_payload_tvalid && output_eth_payload_tready
                        && input_eth_payload_tlast) begin
                    w_frame_cnt_d = r_frame_cnt_q + 32'd1;
                    w_state_d     = IDLE;
                end
            end
            DROP: begin
                w_in_pl_ready = 1'b1;
                if (input_eth_payload_tvalid && input_eth_payload_tlast) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_hdr_valid_q <= 1'b0;
            r_dest_mac_q  <= 48'd0;
            r_src_mac_q   <= 48'd0;
            r_type_q      <= 16'd0;
            r_frame_cnt_q <= 32'd0;
            r_drop_cnt_q  <= 32'd0;
        end else begin
            r_state_q     <= w_state_d;
            r_hdr_valid_q <= w_hdr_valid_d;
            r_dest_mac_q  <= w_dest_mac_d;
            r_src_mac_q   <= w_src_mac_d;
            r_type_q      <= w_type_d;
            r_frame_cnt_q <= w_frame_cnt_d;
            r_drop_cnt_q  <= w_drop_cnt_d;
        end
    end

    assign input_eth_hdr_ready       = w_in_hdr_ready;
    assign input_eth_payload_tready  = w_in_pl_ready;

    assign output_eth_hdr_valid      = r_hdr_valid_q;
    assign output_eth_dest_mac       = r_dest_mac_q;
    assign output_eth_src_mac        = r_src_mac_q;
    assign output_eth_type           = r_type_q;

    assign output_eth_payload_tdata  = input_eth_payload_tdata;
    assign output_eth_payload_tkeep  = input_eth_payload_tkeep;
    assign output_eth_payload_tlast  = input_eth_payload_tlast;
    assign output_eth_payload_tuser  = input_eth_payload_tuser;
    assign output_eth_payload_tvalid = w_out_pl_valid;

    assign frame_count = r_frame_cnt_q;
    assign drop_count  = r_drop_cnt_q;
    assign busy        = (r_state_q != IDLE) || r_hdr_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_echo_64.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_echo_64
//  Purpose  : Self-checking bench for eth_echo_64. Two instances share the
//             stimulus: index 0 filters (ENABLE_FILTER=1), index 1 accepts
//             everything. Expected reply headers and beats are queued when a
//             frame is driven and compared as the selected DUT emits them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_eth_echo_64;

    localparam logic [47:0] c_LOCAL   = 48'h02_00_00_00_00_00;
    localparam logic [47:0] c_BCAST   = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] c_FOREIGN = 48'h11_22_33_44_55_66;
    localparam logic [47:0] c_SRC     = 48'h5A_51_52_53_54_55;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] typ;
    } hdr_t;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        hv;
    logic [47:0] hdst, hsrc;
    logic [15:0] htype;
    logic [63:0] td;
    logic [7:0]  tk;
    logic        tv, tl, tu;
    logic        ohr, opr;

    logic [1:0]  ihr, itr, ohv, otv, otl, otu, bsy;
    logic [47:0] odst [2];
    logic [47:0] osrc [2];
    logic [15:0] otyp [2];
    logic [63:0] otd  [2];
    logic [7:0]  otk  [2];
    logic [31:0] fc   [2];
    logic [31:0] dc   [2];

    hdr_t  exp_hdr  [$];
    beat_t exp_beat [$];

    int n_checks   = 0;
    int n_fail     = 0;
    int exp_frames = 0;
    int exp_drops  = 0;
    int cyc        = 0;
    int hold_until = 0;
    logic bp_en    = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    eth_echo_64 #(.LOCAL_MAC(c_LOCAL), .ENABLE_FILTER(1)) dut (
        .clk(clk), .rst(rst),
        .input_eth_hdr_valid(hv & ~sel), .input_eth_hdr_ready(ihr[0]),
        .input_eth_dest_mac(hdst), .input_eth_src_mac(hsrc), .input_eth_type(htype),
        .input_eth_payload_tdata(td), .input_eth_payload_tkeep(tk),
        .input_eth_payload_tvalid(tv & ~sel), .input_eth_payload_tready(itr[0]),
        .input_eth_payload_tlast(tl), .input_eth_payload_tuser(tu),
        .output_eth_hdr_valid(ohv[0]), .output_eth_hdr_ready(ohr),
        .output_eth_dest_mac(odst[0]), .output_eth_src_mac(osrc[0]), .output_eth_type(otyp[0]),
        .output_eth_payload_tdata(otd[0]), .output_eth_payload_tkeep(otk[0]),
        .output_eth_payload_tvalid(otv[0]), .output_eth_payload_tready(opr),
        .output_eth_payload_tlast(otl[0]), .output_eth_payload_tuser(otu[0]),
        .frame_count(fc[0]), .drop_count(dc[0]), .busy(bsy[0])
    );

    eth_echo_64 #(.LOCAL_MAC(c_LOCAL), .ENABLE_FILTER(0)) dut_nf (
        .clk(clk), .rst(rst),
        .input_eth_hdr_valid(hv & sel), .input_eth_hdr_ready(ihr[1]),
        .input_eth_dest_mac(hdst), .input_eth_src_mac(hsrc), .input_eth_type(htype),
        .input_eth_payload_tdata(td), .input_eth_payload_tkeep(tk),
        .input_eth_payload_tvalid(tv & sel), .input_eth_payload_tready(itr[1]),
        .input_eth_payload_tlast(tl), .input_eth_payload_tuser(tu),
        .output_eth_hdr_valid(ohv[1]), .output_eth_hdr_ready(ohr),
        .output_eth_dest_mac(odst[1]), .output_eth_src_mac(osrc[1]), .output_eth_type(otyp[1]),
        .output_eth_payload_tdata(otd[1]), .output_eth_payload_tkeep(otk[1]),
        .output_eth_payload_tvalid(otv[1]), .output_eth_payload_tready(opr),
        .output_eth_payload_tlast(otl[1]), .output_eth_payload_tuser(otu[1]),
        .frame_count(fc[1]), .drop_count(dc[1]), .busy(bsy[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output ready generation; the reply header can be held off for a window.
    always @(posedge clk) begin
        #1;
        opr = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (cyc < hold_until) ohr = 1'b0;
        else                  ohr = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard monitor: compare whatever the selected DUT hands off.
    always @(negedge clk) begin
        hdr_t  h;
        beat_t b;
        if (!rst) begin
            if (ohv[sel] && ohr) begin
                if (exp_hdr.size() == 0) begin
                    check_eq("hdr_unexpected", 64'd1, 64'd0);
                end else begin
                    h = exp_hdr.pop_front();
                    check_eq("hdr_dst",  64'(odst[sel]), 64'(h.dst));
                    check_eq("hdr_src",  64'(osrc[sel]), 64'(h.src));
                    check_eq("hdr_type", 64'(otyp[sel]), 64'(h.typ));
                end
            end
            if (otv[sel] && opr) begin
                if (exp_beat.size() == 0) begin
                    check_eq("beat_unexpected", 64'd1, 64'd0);
                end else begin
                    b = exp_beat.pop_front();
                    check_eq("beat_data", otd[sel], b.d);
                    check_eq("beat_keep", 64'(otk[sel]), 64'(b.k));
                    check_eq("beat_last", 64'(otl[sel]), 64'(b.l));
                    check_eq("beat_user", 64'(otu[sel]), 64'(b.u));
                end
            end
            // No new header may be accepted while a reply header is pending.
            if (ohv[sel]) check_eq("hdr_gate", 64'(ihr[sel]), 64'd0);
        end
    end

    // Drives one frame; abort_after >= 0 stops after that many beats.
    task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] typ, input int nbeats,
                              input logic [7:0] klast, input logic ulast,
                              input logic gaps, input int abort_after);
        logic  acc;
        beat_t bq[$];
        beat_t b;
        int    t;
        logic  first;
        acc = sel || (dst == c_LOCAL) || (dst == c_BCAST);
        for (int i = 0; i < nbeats; i++) begin
            b.d = {$urandom, $urandom};
            b.l = (i == nbeats - 1);
            b.k = b.l ? klast : 8'hFF;
            b.u = b.l ? ulast : 1'b0;
            bq.push_back(b);
        end
        if (acc) begin
            exp_hdr.push_back('{dst: src, src: c_LOCAL, typ: typ});
            foreach (bq[i]) exp_beat.push_back(bq[i]);
            if (!sel) exp_frames++;
        end else begin
            exp_drops++;
        end
        hv = 1'b1; hdst = dst; hsrc = src; htype = typ;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ihr[sel] && t < 2000);
        if (!ihr[sel]) begin
            check_eq("hdr_accept_timeout", 64'd0, 64'd1);
            hv = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        hv = 1'b0;
        first = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            if (abort_after >= 0 && i == abort_after) begin
                tv = 1'b0; tl = 1'b0;
                return;
            end
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
                tv = 1'b0;
                @(posedge clk);
                #1;
            end
            tv = 1'b1; td = bq[i].d; tk = bq[i].k; tl = bq[i].l; tu = bq[i].u;
            t = 0;
            do begin
                @(negedge clk);
                if (first) begin
                    check_eq("hdr_latency", 64'(ohv[sel]), 64'(acc));
                    check_eq("busy_frame",  64'(bsy[sel]), 64'd1);
                    first = 1'b0;
                end
                if (!acc) begin
                    check_eq("drop_tready", 64'(itr[sel]), 64'd1);
                    check_eq("drop_no_out", 64'(otv[sel]), 64'd0);
                end
                t++;
            end while (!itr[sel] && t < 2000);
            if (!itr[sel]) begin
                check_eq("beat_timeout", 64'd0, 64'd1);
                tv = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        tv = 1'b0; tl = 1'b0; tu = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((exp_hdr.size() != 0 || exp_beat.size() != 0 || bsy[sel]) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) check_eq({tag, "_drain_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_frame_count"}, 64'(fc[0]), 64'(exp_frames));
        check_eq({tag, "_drop_count"},  64'(dc[0]), 64'(exp_drops));
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; hv = 1'b0; hdst = '0; hsrc = '0; htype = '0;
        td = '0; tk = '0; tv = 1'b0; tl = 1'b0; tu = 1'b0; ohr = 1'b1; opr = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_hdr_ready", 64'(ihr[0]), 64'd1);
        check_eq("rst_hdr_valid", 64'(ohv[0]), 64'd0);
        check_eq("rst_in_tready", 64'(itr[0]), 64'd0);
        check_eq("rst_out_tvalid", 64'(otv[0]), 64'd0);
        check_eq("rst_busy", 64'(bsy[0]), 64'd0);
        check_counts("rst");

        // Unicast, 3 beats, keep FF/FF/0F.
        @(posedge clk); #1;
        send_frame(c_LOCAL, c_SRC, 16'h8000, 3, 8'h0F, 1'b0, 1'b0, -1);
        drain("unicast");
        check_counts("unicast");

        // Broadcast, single beat.
        send_frame(c_BCAST, 48'hA0_A1_A2_A3_A4_A5, 16'h0800, 1, 8'h3F, 1'b0, 1'b0, -1);
        drain("bcast");
        check_counts("bcast");

        // Foreign destination, filtered out.
        send_frame(c_FOREIGN, 48'hB0_B1_B2_B3_B4_B5, 16'h86DD, 4, 8'hFF, 1'b0, 1'b0, -1);
        drain("foreign");
        check_counts("foreign");

        // Same frame on the unfiltered instance is echoed.
        sel = 1'b1;
        send_frame(c_FOREIGN, 48'hB0_B1_B2_B3_B4_B5, 16'h86DD, 4, 8'hFF, 1'b0, 1'b0, -1);
        drain("nofilter");
        check_eq("nofilter_frame_count", 64'(fc[1]), 64'd1);
        check_eq("nofilter_drop_count",  64'(dc[1]), 64'd0);
        sel = 1'b0;
        @(posedge clk); #1;

        // Back-pressure with the reply header held for 20 cycles.
        bp_en = 1'b1;
        hold_until = cyc + 20;
        send_frame(c_LOCAL, 48'hC0_C1_C2_C3_C4_C5, 16'h1234, 6, 8'h07, 1'b1, 1'b1, -1);
        send_frame(c_BCAST, 48'hD0_D1_D2_D3_D4_D5, 16'h4321, 3, 8'hFF, 1'b0, 1'b1, -1);
        drain("backpressure");
        check_counts("backpressure");
        bp_en = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a forwarded frame.
        send_frame(c_LOCAL, c_SRC, 16'h8000, 5, 8'hFF, 1'b0, 1'b0, 2);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_hdr_valid", 64'(ohv[0]), 64'd0);
        check_eq("mid_rst_dst", 64'(odst[0]), 64'd0);
        check_eq("mid_rst_src", 64'(osrc[0]), 64'd0);
        check_eq("mid_rst_type", 64'(otyp[0]), 64'd0);
        check_eq("mid_rst_busy", 64'(bsy[0]), 64'd0);
        check_eq("mid_rst_hdr_ready", 64'(ihr[0]), 64'd1);
        check_eq("mid_rst_in_tready", 64'(itr[0]), 64'd0);
        exp_hdr.delete();
        exp_beat.delete();
        exp_frames = 0;
        exp_drops  = 0;
        check_counts("mid_rst");
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        send_frame(c_LOCAL, 48'hE0_E1_E2_E3_E4_E5, 16'h0806, 5, 8'h01, 1'b0, 1'b0, -1);
        drain("post_rst");
        check_counts("post_rst");

        // Random back-to-back traffic.
        bp_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            logic [47:0] d;
            case ($urandom_range(0, 3))
                0: d = c_LOCAL;
                1: d = c_BCAST;
                2: d = c_FOREIGN;
                default: d = {$urandom, 16'($urandom)};
            endcase
            send_frame(d, {16'($urandom), $urandom}, 16'($urandom),
                       int'($urandom_range(1, 8)), 8'($urandom_range(1, 255)),
                       1'($urandom_range(0, 1)), 1'b1, -1);
        end
        drain("random");
        check_counts("random");
        bp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_echo_64.md
# eth_echo_64

Ethernet frame responder for the 64-bit datapath. It sits between the receive-side frame parser (`eth_axis_rx_64`) and the transmit-side frame generator (`eth_axis_tx_64`) in `fpga_core`. For every received frame addressed to this station, it emits a reply frame with swapped MAC addresses and the original EtherType and payload. All other frames are discarded.

## Interface
Parameters:
- `LOCAL_MAC`, default `48'h02_00_00_00_00_00`: station MAC address; used for filtering and as the reply source MAC.
- `ENABLE_FILTER`, default `1`: 1 = accept only dest == `LOCAL_MAC` or broadcast; 0 = accept all frames.

Ports:
- `clk`  in  1: sole clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `input_eth_hdr_valid`  in  1: received header valid.
- `input_eth_hdr_ready`  out  1: header accept.
- `input_eth_dest_mac`  in  48: received destination MAC.
- `input_eth_src_mac`  in  48: received source MAC.
- `input_eth_type`  in  16: received EtherType.
- `input_eth_payload_tdata`  in  64; `input_eth_payload_tkeep`  in  8; `input_eth_payload_tvalid`  in  1; `input_eth_payload_tready`  out  1; `input_eth_payload_tlast`  in  1; `input_eth_payload_tuser`  in  1: received payload stream.
- `output_eth_hdr_valid`  out  1: reply header valid.
- `output_eth_hdr_ready`  in  1: reply header accept.
- `output_eth_dest_mac`  out  48: reply destination MAC.
- `output_eth_src_mac`  out  48: reply source MAC.
- `output_eth_type`  out  16: reply EtherType.
- `output_eth_payload_tdata`  out  64; `output_eth_payload_tkeep`  out  8; `output_eth_payload_tvalid`  out  1; `output_eth_payload_tready`  in  1; `output_eth_payload_tlast`  out  1; `output_eth_payload_tuser`  out  1: reply payload stream.
- `frame_count`  out  32: replied frames, incremented on the last beat forwarded.
- `drop_count`  out  32: discarded frames, incremented on the filter reject decision.
- `busy`  out  1: high when state != IDLE or `output_eth_hdr_valid` is set.

## Operation
- FSM states: IDLE, FORWARD, DROP.
- **IDLE**
  - `input_eth_hdr_ready = !output_eth_hdr_valid`.
  - `input_eth_payload_tready = 0`.
  - On a header handshake where the frame is accepted (filter passes, or `ENABLE_FILTER == 0`):
    - register `output_eth_dest_mac <= input_eth_src_mac`.
    - register `output_eth_src_mac <= LOCAL_MAC`.
    - register `output_eth_type <= input_eth_type`.
    - set `output_eth_hdr_valid`.
    - go to FORWARD.
  - On a header handshake where the frame is rejected: `drop_count++`, go to DROP.
- **FORWARD**
  - Payload is a combinational pass-through: tdata, tkeep, tlast and tuser are forwarded unchanged.
  - `output_eth_payload_tvalid = input_eth_payload_tvalid`.
  - `input_eth_payload_tready = output_eth_payload_tready`.
  - On a last-beat transfer: `frame_count++`, go to IDLE.
  - Frames with `tuser = 1` are still forwarded and still counted.
- **DROP**
  - `input_eth_payload_tready = 1`; output payload tvalid = 0.
  - On a transfer with tlast = 1: go to IDLE.
- **Output header**: `output_eth_hdr_valid` clears on its handshake. It is independent of payload progress, so it may complete before, during or after the payload.
- **Filter**: broadcast is `48'hFF_FF_FF_FF_FF_FF`.
- **Counters**: 32-bit, wrap modulo 2^32, no saturation.

## Timing
- Reset values, applied asynchronously:
  - state = IDLE.
  - `output_eth_hdr_valid = 0`.
  - output header fields = 0.
  - `frame_count = 0`, `drop_count = 0`.
  - `busy = 0`.
  - Hence `input_eth_hdr_ready = 1` and both payload tready/tvalid outputs = 0.
- Header latency: a header handshake in cycle N gives `output_eth_hdr_valid = 1` from cycle N+1.
- Payload latency: 0 cycles; the first payload beat may pass from cycle N+1.
- Throughput: one beat per cycle under continuous ready.
- A frame ending in cycle M: the next header is accepted no earlier than M+1, and only once the previous reply header has been accepted.
- A single-beat frame (tlast on the first beat) follows the normal path; the header and payload handshakes may occur in the same cycle.
- Reset mid-frame: the partial frame is abandoned. Neither counter changes for it.

## Test plan
- Accept a unicast frame: header dest=`LOCAL_MAC`, src `5A:51:52:53:54:55`, type `0x8000`, 3 beats with tkeep `FF/FF/0F`.
  - Required: reply header dest `5A:51:52:53:54:55`, src `LOCAL_MAC`, type `0x8000`, valid at N+1.
  - Required: payload bit-identical; `frame_count = 1`.
- Broadcast frame, 1 beat: reply emitted; header and payload handshakes in the same cycle are allowed; `frame_count` increments.
- Frame to `11:22:33:44:55:66` with `ENABLE_FILTER = 1`, 4 beats:
  - Required: input tready = 1 throughout; no output valid; `drop_count = 1`.
  - Repeat with `ENABLE_FILTER = 0`: the frame is echoed.
- Back-pressure: `output_eth_payload_tready` toggled randomly and `output_eth_hdr_ready` held low for 20 cycles.
  - Required: payload stalls only via ready; no beat lost or duplicated.
  - Required: the next header is not accepted until the held reply header completes.
- Reset mid-FORWARD, after 2 of 5 beats:
  - Required: outputs return to reset values immediately; counters = 0.
  - Required: the next full frame is echoed correctly.
- 1000 back-to-back frames of random length, mixing unicast, broadcast and foreign destinations:
  - Required: counters match the scoreboard; a `tuser = 1` last beat is forwarded with tuser = 1.
